led_pulse_stretcher: RTL and testbench

Output-side counterpart of the switch debouncer. The debouncer turns human-speed switch input into clean clock-domain levels. This block turns clock-domain events into human-visible LED blinks: one blink of fixed on-time per rising edge of i_Event, with a fixed dark gap between consecutive blinks. Events that arrive while a blink is in progress are queued in a saturating pending counter. Events beyond that capacity are dropped and flagged.

---
 rtl/led_pulse_stretcher.sv | 104 ++++++++++
 tb/tb_led_pulse_stretcher.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_pulse_stretcher.sv
// rtl/led_pulse_stretcher.sv - one fixed-length LED blink per input rising edge
// Rises that arrive while busy are queued up to c_PEND_MAX, with a dark gap between blinks.
module led_pulse_stretcher #(
  parameter int c_ON_TICKS  = 2500000,
  parameter int c_OFF_TICKS = 1250000,
  parameter int c_CNT_W     = 22,
  parameter int c_PEND_MAX  = 7,
  parameter int c_PEND_W    = 3
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Event,
  output logic                o_LED,
  output logic                o_Busy,
  output logic [c_PEND_W-1:0] o_Pend_Count,
  output logic                o_Drop
);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} state_t;

  localparam logic [c_CNT_W-1:0]  ON_LAST  = c_CNT_W'(c_ON_TICKS - 1);
  localparam logic [c_CNT_W-1:0]  OFF_LAST = c_CNT_W'(c_OFF_TICKS - 1);
  localparam logic [c_PEND_W-1:0] PEND_TOP = c_PEND_W'(c_PEND_MAX);

  state_t                state_q, state_d;
  logic [c_CNT_W-1:0]    cnt_q, cnt_d;
  logic [c_PEND_W-1:0]   pend_q, pend_d;
  logic                  evt_prev_q;
  logic                  led_q, busy_q, drop_q, drop_d;
  logic                  rise, gap_end, queue_rise;

  assign rise    = i_Event & ~evt_prev_q;
  assign gap_end = (state_q == S_GAP) && (cnt_q == OFF_LAST);
  // The terminal gap cycle consumes its rise directly instead of queueing it.
  assign queue_rise = rise && (state_q != S_IDLE) && !gap_end;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + c_CNT_W'(1);
    pend_d  = pend_q;
    drop_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        pend_d = '0;
        if (rise) state_d = S_ON;
      end
      S_ON: begin
        if (cnt_q == ON_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        if (gap_end) begin
          cnt_d = '0;
          if (pend_q != '0) begin
            state_d = S_ON;
            if (!rise) pend_d = pend_q - c_PEND_W'(1);
          end else if (rise) begin
            state_d = S_ON;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        pend_d  = '0;
      end
    endcase
    if (queue_rise) begin
      if (pend_q < PEND_TOP) pend_d = pend_q + c_PEND_W'(1);
      else                   drop_d = 1'b1;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pend_q     <= '0;
      evt_prev_q <= 1'b1;
      led_q      <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      evt_prev_q <= i_Event;
      led_q      <= (state_d == S_ON);
      busy_q     <= (state_d != S_IDLE);
      drop_q     <= drop_d;
    end
  end

  assign o_LED        = led_q;
  assign o_Busy       = busy_q;
  assign o_Pend_Count = pend_q;
  assign o_Drop       = drop_q;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// tb/tb_led_pulse_stretcher.sv - randomized and directed checks against a blink-schedule model
module tb_led_pulse_stretcher;

  localparam int ON   = 4;
  localparam int OFF  = 3;
  localparam int PMAX = 2;

  logic       clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic       i_Event = 1'b0;
  logic       o_LED, o_Busy, o_Drop;
  logic [1:0] o_Pend_Count;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Model: every accepted event becomes a scheduled blink start edge.
  int         starts[$];
  logic       prev = 1'b1;
  logic       m_led, m_busy, m_drop;
  logic [1:0] m_pend;

  always #5 clk = ~clk;

  led_pulse_stretcher #(
    .c_ON_TICKS(ON), .c_OFF_TICKS(OFF), .c_CNT_W(3), .c_PEND_MAX(PMAX), .c_PEND_W(2)
  ) dut (
    .i_Clk(clk), .i_Rst(i_Rst), .i_Event(i_Event),
    .o_LED(o_LED), .o_Busy(o_Busy), .o_Pend_Count(o_Pend_Count), .o_Drop(o_Drop)
  );

  task automatic step(input logic ev);
    int last_end;
    int p;
    logic rise;
    i_Event = ev;
    @(posedge clk);
    cyc++;
    m_drop = 1'b0;
    if (i_Rst) begin
      starts.delete();
      prev = 1'b1;
    end else begin
      rise = ev & ~prev;
      prev = ev;
      if (rise) begin
        last_end = (starts.size() == 0) ? -1000 : starts[starts.size()-1] + ON + OFF;
        if (cyc >= last_end) starts.push_back(cyc);
        else begin
          p = 0;
          foreach (starts[i]) if (starts[i] > cyc) p++;
          if (p < PMAX) starts.push_back(last_end);
          else m_drop = 1'b1;
        end
      end
    end
    m_led = 1'b0; m_busy = 1'b0; m_pend = 2'd0;
    foreach (starts[i]) begin
      if (starts[i] <= cyc && cyc < starts[i] + ON) m_led = 1'b1;
      if (starts[i] <= cyc && cyc < starts[i] + ON + OFF) m_busy = 1'b1;
      if (starts[i] > cyc) m_pend = m_pend + 2'd1;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b0);
    step(1'b0);
    tests++;
    if ({o_LED, o_Busy, o_Pend_Count, o_Drop} !== 5'b0) begin
      fails++;
      $display("FAIL reset_state: got led=%b busy=%b pend=%0d drop=%b, want all 0", o_LED, o_Busy, o_Pend_Count, o_Drop);
    end
    i_Rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      tests++;
      if ({o_LED, o_Busy, o_Pend_Count, o_Drop} !== {m_led, m_busy, m_pend, m_drop}) begin
        fails++;
        $display("FAIL reset_idle cyc %0d: got %b%b%0d%b want %b%b%0d%b", cyc, o_LED, o_Busy, o_Pend_Count, o_Drop, m_led, m_busy, m_pend, m_drop);
      end
    end
  endtask

  task automatic test_single_pulse();
    int led_n = 0;
    int busy_n = 0;
    for (int i = 0; i < 14; i++) begin
      step(i == 0);
      led_n += int'(o_LED);
      busy_n += int'(o_Busy);
      tests++;
      if ({o_LED, o_Busy, o_Pend_Count, o_Drop} !== {m_led, m_busy, m_pend, m_drop}) begin
        fails++;
        $display("FAIL single_pulse cyc %0d: got %b%b%0d%b want %b%b%0d%b", cyc, o_LED, o_Busy, o_Pend_Count, o_Drop, m_led, m_busy, m_pend, m_drop);
      end
    end
    tests++;
    if (led_n != ON || busy_n != ON + OFF) begin
      fails++;
      $display("FAIL single_pulse_len: got on=%0d busy=%0d want on=%0d busy=%0d", led_n, busy_n, ON, ON + OFF);
    end
  endtask

  task automatic test_held_level();
    int led_n = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1);
      led_n += int'(o_LED);
      tests++;
      if ({o_LED, o_Busy, o_Pend_Count, o_Drop} !== {m_led, m_busy, m_pend, m_drop}) begin
        fails++;
        $display("FAIL held_level cyc %0d: got %b%b%0d%b want %b%b%0d%b", cyc, o_LED, o_Busy, o_Pend_Count, o_Drop, m_led, m_busy, m_pend, m_drop);
      end
    end
    tests++;
    if (led_n != ON || o_Busy !== 1'b0) begin
      fails++;
      $display("FAIL held_level_once: got on=%0d busy=%b want on=%0d busy=0", led_n, o_Busy, ON);
    end
    step(1'b0);
  endtask

  task automatic test_queue_drop();
    logic seq[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int drops = 0;
    int blinks = 0;
    logic led_prev = 1'b0;
    for (int i = 0; i < 32; i++) begin
      step(i < 7 ? seq[i] : 1'b0);
      drops += int'(o_Drop);
      if (o_LED && !led_prev) blinks++;
      led_prev = o_LED;
      tests++;
      if ({o_LED, o_Busy, o_Pend_Count, o_Drop} !== {m_led, m_busy, m_pend, m_drop}) begin
        fails++;
        $display("FAIL queue_drop cyc %0d: got %b%b%0d%b want %b%b%0d%b", cyc, o_LED, o_Busy, o_Pend_Count, o_Drop, m_led, m_busy, m_pend, m_drop);
      end
    end
    tests++;
    if (drops != 1 || blinks != 3 || o_Busy !== 1'b0) begin
      fails++;
      $display("FAIL queue_drop_totals: got drops=%0d blinks=%0d busy=%b want 1 3 0", drops, blinks, o_Busy);
    end
  endtask

  task automatic test_terminal_rise();
    // Pass 0: rise only at the last gap clock. Pass 1: one event already queued.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 26; i++) begin
        step(i == 0 || i == ON + OFF || (pass == 1 && i == 2));
        tests++;
        if ({o_LED, o_Busy, o_Pend_Count, o_Drop} !== {m_led, m_busy, m_pend, m_drop}) begin
          fails++;
          $display("FAIL terminal_rise p%0d cyc %0d: got %b%b%0d%b want %b%b%0d%b", pass, cyc, o_LED, o_Busy, o_Pend_Count, o_Drop, m_led, m_busy, m_pend, m_drop);
        end
        if (i == ON + OFF) begin
          tests++;
          if (o_LED !== 1'b1 || o_Busy !== 1'b1 || o_Pend_Count !== 2'(pass) || o_Drop !== 1'b0) begin
            fails++;
            $display("FAIL terminal_edge p%0d: got led=%b busy=%b pend=%0d drop=%b want 1 1 %0d 0", pass, o_LED, o_Busy, o_Pend_Count, o_Drop, pass);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int led_n = 0;
    for (int i = 0; i < 9; i++) step(i < 7 && (i % 2 == 0));
    tests++;
    if (o_LED !== 1'b1 || o_Pend_Count !== 2'd1) begin
      fails++;
      $display("FAIL reset_mid_pre: got led=%b pend=%0d want led=1 pend=1", o_LED, o_Pend_Count);
    end
    #3 i_Rst = 1'b1;
    #1;
    tests++;
    if ({o_LED, o_Busy, o_Pend_Count} !== 4'b0) begin
      fails++;
      $display("FAIL reset_async: got led=%b busy=%b pend=%0d want 0 0 0", o_LED, o_Busy, o_Pend_Count);
    end
    step(1'b1);
    step(1'b1);
    i_Rst = 1'b0;
    for (int i = 0; i < 26; i++) begin
      step(i < 10 || i > 10);
      led_n += int'(o_LED);
      tests++;
      if ({o_LED, o_Busy, o_Pend_Count, o_Drop} !== {m_led, m_busy, m_pend, m_drop}) begin
        fails++;
        $display("FAIL reset_mid cyc %0d: got %b%b%0d%b want %b%b%0d%b", cyc, o_LED, o_Busy, o_Pend_Count, o_Drop, m_led, m_busy, m_pend, m_drop);
      end
    end
    tests++;
    if (led_n != ON) begin
      fails++;
      $display("FAIL reset_mid_one_blink: got on=%0d want %0d", led_n, ON);
    end
    step(1'b0);
  endtask

  task automatic test_random();
    logic ev = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) ev = ~ev;
      step(ev);
      tests++;
      if ({o_LED, o_Busy, o_Pend_Count, o_Drop} !== {m_led, m_busy, m_pend, m_drop}) begin
        fails++;
        $display("FAIL random cyc %0d: got %b%b%0d%b want %b%b%0d%b", cyc, o_LED, o_Busy, o_Pend_Count, o_Drop, m_led, m_busy, m_pend, m_drop);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_held_level();
    test_queue_drop();
    test_terminal_rise();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
